register_writeback: RTL

//   Write-side front end of the general-purpose register file. Merges single-cycle ALU

---
 rtl/register_writeback_pkg.sv | 19 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/register_writeback.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/register_writeback_pkg.sv
// Shared types for the register-file write side.
//   t_register_index : 5-bit architectural register number (x0 is hardwired zero)
//   t_data           : 32-bit register value
//   t_wb_entry       : one pending write (destination + value), as buffered for loads
package register_writeback_pkg;

   localparam int NUM_REGS = 32;

   typedef logic [4:0]  t_register_index;
   typedef logic [31:0] t_data;

   typedef struct packed {
      t_register_index rd;
      t_data           data;
   } t_wb_entry;

   localparam t_register_index REG_ZERO = '0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO of an arbitrary packed element type.
//   i_clk, i_reset : clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data : write one element; ignored when full unless popping the same cycle
//   i_pop, o_data  : o_data is the head; i_pop removes it (ignored when empty)
//   o_full/o_empty : occupancy flags, registered state only
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter type T = logic [7:0]
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_push,
   input  T     i_data,
   input  logic i_pop,
   output T     o_data,
   output logic o_full,
   output logic o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   T              mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   cnt_q,  cnt_d;
   logic          do_push, do_pop;

   assign o_full  = (cnt_q == CNT_FULL);
   assign o_empty = (cnt_q == '0);
   assign o_data  = mem_q[rptr_q];

   assign do_pop  = i_pop && !o_empty;
   // A pop in the same cycle frees the slot being written.
   assign do_push = i_push && (!o_full || do_pop);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wptr_q] <= i_data;
   end

endmodule

// File: rtl/register_writeback.sv
// Write-side front end of the GPR file.
//   i_clk, i_reset              : clock, synchronous active-high reset
//   i_issue_*, o_issue_ready    : destination reservation; stalls when the reg's counter is full
//   i_alu_*                     : single-cycle results, highest priority, never stalled
//   i_load_*, o_load_ready      : multi-cycle results, buffered in a small FIFO
//   o_rf_*                      : registered register-file write port
//   i_read_idx1/2, o_fwd_*      : bypass of the in-flight write to the two read ports
//   o_busy                      : per-register "write outstanding" flags
//   o_error                     : sticky, a result committed to a register with no reservation
module register_writeback
   import register_writeback_pkg::*;
#(
   parameter int LOAD_FIFO_DEPTH = 4,
   parameter int PEND_W          = 2
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_issue_valid,
   input  t_register_index i_issue_rd,
   output logic            o_issue_ready,
   input  logic            i_alu_valid,
   input  t_register_index i_alu_rd,
   input  t_data           i_alu_data,
   input  logic            i_load_valid,
   output logic            o_load_ready,
   input  t_register_index i_load_rd,
   input  t_data           i_load_data,
   output logic            o_rf_write_enable,
   output t_register_index o_rf_rd,
   output t_data           o_rf_data,
   input  t_register_index i_read_idx1,
   input  t_register_index i_read_idx2,
   output logic            o_fwd_valid1,
   output logic            o_fwd_valid2,
   output t_data           o_fwd_data1,
   output t_data           o_fwd_data2,
   output logic [31:0]     o_busy,
   output logic            o_error
);

   localparam logic [PEND_W-1:0] CNT_MAX = '1;

   t_wb_entry load_entry, alu_entry, head, sel;
   logic      fifo_full, fifo_empty, load_push;
   logic      alu_sel, fifo_sel, sel_valid, issue_acc;

   logic            we_q, we_d;
   t_register_index rd_q, rd_d;
   t_data           data_q, data_d;
   logic [NUM_REGS-1:0][PEND_W-1:0] cnt_q, cnt_d;
   logic            error_q, error_d;

   // ---------------- load buffer ----------------
   assign load_entry   = '{rd: i_load_rd, data: i_load_data};
   assign o_load_ready = !fifo_full;
   // x0 loads are handshaken but never stored.
   assign load_push    = i_load_valid && o_load_ready && (i_load_rd != REG_ZERO);

   sync_fifo #(
      .DEPTH (LOAD_FIFO_DEPTH),
      .T     (t_wb_entry)
   ) u_load_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (load_push),
      .i_data  (load_entry),
      .i_pop   (fifo_sel),
      .o_data  (head),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   // ---------------- arbiter ----------------
   assign alu_entry = '{rd: i_alu_rd, data: i_alu_data};
   assign alu_sel   = i_alu_valid && (i_alu_rd != REG_ZERO);
   assign fifo_sel  = !alu_sel && !fifo_empty;
   assign sel_valid = alu_sel || fifo_sel;
   assign sel       = alu_sel ? alu_entry : head;

   // ---------------- output register ----------------
   always_comb begin
      we_d   = sel_valid;
      rd_d   = rd_q;
      data_d = data_q;
      if (sel_valid) begin
         rd_d   = sel.rd;
         data_d = sel.data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         we_q   <= 1'b0;
         rd_q   <= '0;
         data_q <= '0;
      end else begin
         we_q   <= we_d;
         rd_q   <= rd_d;
         data_q <= data_d;
      end
   end

   assign o_rf_write_enable = we_q;
   assign o_rf_rd           = rd_q;
   assign o_rf_data         = data_q;

   // ---------------- scoreboard ----------------
   // A commit to the same register this cycle frees a slot, so a saturated
   // register can still take an issue (net change zero). cnt_q[0] stays 0,
   // which keeps x0 issues always ready.
   assign o_issue_ready = (cnt_q[i_issue_rd] != CNT_MAX) ||
                          (sel_valid && (sel.rd == i_issue_rd));
   assign issue_acc     = i_issue_valid && o_issue_ready && (i_issue_rd != REG_ZERO);

   always_comb begin
      cnt_d   = cnt_q;
      error_d = error_q;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (sel_valid && (sel.rd == t_register_index'(r))) begin
            if (cnt_q[r] == '0)
               error_d = 1'b1;
            else if (!(issue_acc && (i_issue_rd == t_register_index'(r))))
               cnt_d[r] = cnt_q[r] - 1'b1;
         end else if (issue_acc && (i_issue_rd == t_register_index'(r))) begin
            cnt_d[r] = cnt_q[r] + 1'b1;
         end
      end
      cnt_d[0] = '0;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt_q   <= '0;
         error_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      o_busy = '0;
      for (int r = 1; r < NUM_REGS; r++) o_busy[r] = (cnt_q[r] != '0);
   end

   assign o_error = error_q;

   // ---------------- forwarding ----------------
   // Busy has already dropped when the write sits in o_rf_*, but the register
   // file only holds the value after the next edge; bridge that cycle.
   assign o_fwd_valid1 = we_q && (rd_q == i_read_idx1) && (i_read_idx1 != REG_ZERO);
   assign o_fwd_valid2 = we_q && (rd_q == i_read_idx2) && (i_read_idx2 != REG_ZERO);
   assign o_fwd_data1  = data_q;
   assign o_fwd_data2  = data_q;

endmodule
